// File: rtl/register_tree_pkg.sv
// Shared types for the register_tree replace-interface driver: key type,
// driver FSM state encoding and a helper that sizes the settle timer.
package register_tree_pkg;

  localparam int RT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    PULSE  = 2'd2,
    SETTLE = 2'd3
  } rt_drv_state_t;

  typedef logic [RT_DATA_WIDTH-1:0] rt_key_t;

  // Bits needed to hold a settle count of 0..settle; never narrower than 1.
  function automatic int rt_timer_width(input int settle);
    if (settle < 2) begin
      return 1;
    end
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/rt_settle_timer.sv
// Loadable down-counter that paces the driver FSM. It restarts from
// RESET_VALUE on reset (tree power-up settle) or from value_i on load
// (post-replace settle). done_o flags that the count expires at the coming
// edge, so a FSM leaving on done_o spends exactly the programmed cycles.
module rt_settle_timer
  import register_tree_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register, restarting the power-up settle on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q <= WIDTH'(1));

endmodule

// File: rtl/register_tree_driver.sv
// Initiator for the register_tree replace port. Accepts keys on a
// valid/ready stream, fires one-cycle replace pulses spaced so the tree top
// has settled before it is sampled again, and hands back each popped top on
// a one-entry valid/ready result buffer.
module register_tree_driver
  import register_tree_pkg::*;
#(
  parameter int QUEUE_SIZE    = 8,
  parameter int DATA_WIDTH    = RT_DATA_WIDTH,
  parameter int SETTLE_CYCLES = $clog2(QUEUE_SIZE),
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   o_replace,
  output logic [DATA_WIDTH-1:0]  o_new_data,
  input  logic [DATA_WIDTH-1:0]  i_top,
  output logic                   o_top_valid,
  output logic [COUNT_WIDTH-1:0] o_op_count
);

  localparam int                     TIMER_WIDTH  = rt_timer_width(SETTLE_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] SETTLE_VALUE = TIMER_WIDTH'(SETTLE_CYCLES);

  rt_drv_state_t          state_q;
  rt_drv_state_t          state_d;
  logic                   m_valid_q;
  logic                   m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q;
  logic [DATA_WIDTH-1:0]  m_data_d;
  logic                   replace_q;
  logic                   replace_d;
  logic [DATA_WIDTH-1:0]  new_data_q;
  logic [DATA_WIDTH-1:0]  new_data_d;
  logic [COUNT_WIDTH-1:0] op_count_q;
  logic [COUNT_WIDTH-1:0] op_count_d;

  logic in_idle;
  logic accept;
  logic timer_done;

  // Keys are only taken in IDLE and only when the result slot can be freed,
  // so a stalled consumer freezes the tree top.
  assign in_idle = (state_q == IDLE);
  assign s_ready = in_idle && (!m_valid_q || m_ready);
  assign accept  = s_valid && s_ready;

  // One timer paces both the post-reset wait and the post-replace settle.
  rt_settle_timer #(
    .WIDTH       (TIMER_WIDTH),
    .RESET_VALUE (SETTLE_VALUE)
  ) u_settle_timer (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .load_i  (accept),
    .value_i (SETTLE_VALUE),
    .done_o  (timer_done)
  );

  // Sequencing: wait for tree settle, accept, pulse once, settle again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (timer_done) state_d = IDLE;
      IDLE:    if (accept)     state_d = PULSE;
      PULSE:                   state_d = SETTLE;
      SETTLE:  if (timer_done) state_d = IDLE;
      default:                 state_d = INIT;
    endcase
  end

  // Datapath next values: an accept captures the outgoing top, launches the
  // new key and bumps the op counter; otherwise values hold, except the
  // result slot empties once the consumer takes it.
  always_comb begin
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    replace_d  = 1'b0;
    new_data_d = new_data_q;
    op_count_d = op_count_q;
    if (accept) begin
      m_valid_d  = 1'b1;
      m_data_d   = i_top;
      replace_d  = 1'b1;
      new_data_d = s_data;
      op_count_d = op_count_q + COUNT_WIDTH'(1);
    end else if (m_ready) begin
      m_valid_d  = 1'b0;
    end
  end

  // State and datapath registers; reset drops any pending result.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= INIT;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      replace_q  <= 1'b0;
      new_data_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      replace_q  <= replace_d;
      new_data_q <= new_data_d;
      op_count_q <= op_count_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign o_replace   = replace_q;
  assign o_new_data  = new_data_q;
  assign o_op_count  = op_count_q;
  assign o_top_valid = in_idle;

endmodule

// File: tb/tb_register_tree_driver.sv
// Directed bench for register_tree_driver driving a small behavioural tree
// (8 entries, all 80 after reset, replace = pop minimum then insert).
module tb_register_tree_driver;

  localparam int DW = 32;
  localparam int QS = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          sValid = 1'b0;
  logic          sReady;
  logic [DW-1:0] sData = '0;
  logic          mValid;
  logic          mReady = 1'b1;
  logic [DW-1:0] mData;
  logic          oReplace;
  logic [DW-1:0] oNewData;
  logic [DW-1:0] iTop;
  logic          oTopValid;
  logic [CW-1:0] opCount;

  int assertCount = 0;
  int failCount = 0;

  always #5 CLK = ~CLK;

  register_tree_driver #(
    .QUEUE_SIZE    (QS),
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (3),
    .COUNT_WIDTH   (CW)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .s_valid     (sValid),
    .s_ready     (sReady),
    .s_data      (sData),
    .m_valid     (mValid),
    .m_ready     (mReady),
    .m_data      (mData),
    .o_replace   (oReplace),
    .o_new_data  (oNewData),
    .i_top       (iTop),
    .o_top_valid (oTopValid),
    .o_op_count  (opCount)
  );

  // Behavioural tree: top is the smallest entry; a replace overwrites it.
  logic [DW-1:0] treeMem [QS];
  int            minIdx;

  always_comb begin
    minIdx = 0;
    iTop   = treeMem[0];
    for (int k = 1; k < QS; k++) begin
      if (treeMem[k] < iTop) begin
        iTop   = treeMem[k];
        minIdx = k;
      end
    end
  end

  // Tree storage shares the driver reset and reloads 80 everywhere.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < QS; k++) treeMem[k] <= 32'd80;
    end else if (oReplace) begin
      treeMem[minIdx] <= oNewData;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitPulse(output int ticks);
    ticks = 0;
    do begin
      tick();
      ticks++;
    end while (!oReplace && ticks < 20);
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (!oTopValid && guard < 20) begin
      tick();
      guard++;
    end
  endtask

  task automatic test_init_release();
    RSTn = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      assertCount++;
      if (sReady !== 1'b0) begin failCount++; $display("[TB] FAIL init_s_ready cycle %0d: got %b expected 0", c, sReady); end
      assertCount++;
      if (oReplace !== 1'b0) begin failCount++; $display("[TB] FAIL init_replace cycle %0d: got %b expected 0", c, oReplace); end
      assertCount++;
      if (mValid !== 1'b0) begin failCount++; $display("[TB] FAIL init_m_valid cycle %0d: got %b expected 0", c, mValid); end
      assertCount++;
      if (oTopValid !== 1'b0) begin failCount++; $display("[TB] FAIL init_top_valid cycle %0d: got %b expected 0", c, oTopValid); end
      tick();
    end
    assertCount++;
    if (sReady !== 1'b1) begin failCount++; $display("[TB] FAIL idle_s_ready: got %b expected 1", sReady); end
    assertCount++;
    if (oTopValid !== 1'b1) begin failCount++; $display("[TB] FAIL idle_top_valid: got %b expected 1", oTopValid); end
    assertCount++;
    if (mValid !== 1'b0) begin failCount++; $display("[TB] FAIL idle_m_valid: got %b expected 0", mValid); end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; sValid = 1'b0; mReady = 1'b1; sData = '0;
    repeat (2) tick();
    assertCount++;
    if (sReady !== 1'b0) begin failCount++; $display("[TB] FAIL reset_s_ready: got %b expected 0", sReady); end
    assertCount++;
    if (mValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_m_valid: got %b expected 0", mValid); end
    assertCount++;
    if (oReplace !== 1'b0) begin failCount++; $display("[TB] FAIL reset_replace: got %b expected 0", oReplace); end
    assertCount++;
    if (opCount !== 4'd0) begin failCount++; $display("[TB] FAIL reset_op_count: got %0d expected 0", opCount); end
    assertCount++;
    if (mData !== 32'd0 || oNewData !== 32'd0) begin failCount++; $display("[TB] FAIL reset_data: got m_data %0d new_data %0d expected 0 0", mData, oNewData); end
    test_init_release();
  endtask

  task automatic test_single();
    sData = 32'd5; sValid = 1'b1; mReady = 1'b1;
    tick();
    assertCount++;
    if (oReplace !== 1'b1) begin failCount++; $display("[TB] FAIL single_replace: got %b expected 1", oReplace); end
    assertCount++;
    if (oNewData !== 32'd5) begin failCount++; $display("[TB] FAIL single_new_data: got %0d expected 5", oNewData); end
    assertCount++;
    if (mData !== 32'd80 || mValid !== 1'b1) begin failCount++; $display("[TB] FAIL single_result: got m_data %0d m_valid %b expected 80 1", mData, mValid); end
    assertCount++;
    if (opCount !== 4'd1) begin failCount++; $display("[TB] FAIL single_op_count: got %0d expected 1", opCount); end
    assertCount++;
    if (sReady !== 1'b0) begin failCount++; $display("[TB] FAIL single_s_ready_pulse: got %b expected 0", sReady); end
    sValid = 1'b0; sData = 32'd99;
    for (int c = 0; c < 3; c++) begin
      tick();
      assertCount++;
      if (sReady !== (c == 2)) begin failCount++; $display("[TB] FAIL single_s_ready cycle %0d: got %b expected %b", c, sReady, (c == 2)); end
      assertCount++;
      if (oReplace !== 1'b0 || oNewData !== 32'd5) begin failCount++; $display("[TB] FAIL single_hold cycle %0d: got replace %b new_data %0d expected 0 5", c, oReplace, oNewData); end
    end
    assertCount++;
    if (mValid !== 1'b0) begin failCount++; $display("[TB] FAIL single_m_valid_clear: got %b expected 0", mValid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] keys [8];
    logic [DW-1:0] pops [8];
    int t;
    keys = '{32'd100, 32'd3, 32'd200, 32'd50, 32'd7, 32'd256, 32'd1, 32'd90};
    pops = '{32'd5, 32'd80, 32'd3, 32'd80, 32'd50, 32'd7, 32'd80, 32'd1};
    mReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sData = keys[i]; sValid = 1'b1;
      waitPulse(t);
      assertCount++;
      if (t != ((i == 0) ? 1 : 4)) begin failCount++; $display("[TB] FAIL b2b_spacing op %0d: got %0d cycles expected %0d", i, t, (i == 0) ? 1 : 4); end
      assertCount++;
      if (mData !== pops[i] || mValid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_pop op %0d: got %0d valid %b expected %0d 1", i, mData, mValid, pops[i]); end
      assertCount++;
      if (oNewData !== keys[i]) begin failCount++; $display("[TB] FAIL b2b_new_data op %0d: got %0d expected %0d", i, oNewData, keys[i]); end
    end
    sValid = 1'b0;
    assertCount++;
    if (opCount !== 4'd9) begin failCount++; $display("[TB] FAIL b2b_op_count: got %0d expected 9", opCount); end
    waitIdle();
  endtask

  task automatic test_backpressure();
    mReady = 1'b0; sData = 32'd40; sValid = 1'b1;
    tick();
    assertCount++;
    if (oReplace !== 1'b1 || mData !== 32'd80) begin failCount++; $display("[TB] FAIL bp_first: got replace %b m_data %0d expected 1 80", oReplace, mData); end
    sData = 32'd60;
    for (int c = 0; c < 8; c++) begin
      tick();
      assertCount++;
      if (mValid !== 1'b1 || mData !== 32'd80) begin failCount++; $display("[TB] FAIL bp_hold cycle %0d: got valid %b m_data %0d expected 1 80", c, mValid, mData); end
      assertCount++;
      if (sReady !== 1'b0 || oReplace !== 1'b0) begin failCount++; $display("[TB] FAIL bp_stall cycle %0d: got s_ready %b replace %b expected 0 0", c, sReady, oReplace); end
    end
    assertCount++;
    if (oTopValid !== 1'b1) begin failCount++; $display("[TB] FAIL bp_idle: got %b expected 1", oTopValid); end
    mReady = 1'b1;
    #1;
    assertCount++;
    if (sReady !== 1'b1) begin failCount++; $display("[TB] FAIL bp_release_ready: got %b expected 1", sReady); end
    tick();
    assertCount++;
    if (oReplace !== 1'b1 || mValid !== 1'b1 || mData !== 32'd40) begin failCount++; $display("[TB] FAIL bp_same_cycle: got replace %b valid %b m_data %0d expected 1 1 40", oReplace, mValid, mData); end
    assertCount++;
    if (oNewData !== 32'd60 || opCount !== 4'd11) begin failCount++; $display("[TB] FAIL bp_new_data_count: got %0d %0d expected 60 11", oNewData, opCount); end
    sValid = 1'b0;
    waitIdle();
  endtask

  task automatic test_reset_mid();
    mReady = 1'b0; sData = 32'd9; sValid = 1'b1;
    tick();
    sValid = 1'b0;
    tick();
    assertCount++;
    if (mValid !== 1'b1 || opCount !== 4'd12) begin failCount++; $display("[TB] FAIL mid_pre: got valid %b count %0d expected 1 12", mValid, opCount); end
    RSTn = 1'b0;
    #1;
    assertCount++;
    if (mValid !== 1'b0 || oReplace !== 1'b0) begin failCount++; $display("[TB] FAIL mid_async_flags: got valid %b replace %b expected 0 0", mValid, oReplace); end
    assertCount++;
    if (opCount !== 4'd0 || mData !== 32'd0) begin failCount++; $display("[TB] FAIL mid_async_data: got count %0d m_data %0d expected 0 0", opCount, mData); end
    assertCount++;
    if (oTopValid !== 1'b0) begin failCount++; $display("[TB] FAIL mid_top_valid: got %b expected 0", oTopValid); end
    tick();
    mReady = 1'b1;
    test_init_release();
  endtask

  task automatic test_wrap();
    int t;
    logic [CW-1:0] expCount;
    mReady = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sData = DW'(i + 1); sValid = 1'b1;
      waitPulse(t);
      expCount = CW'(i + 1);
      assertCount++;
      if (oReplace !== 1'b1 || opCount !== expCount) begin failCount++; $display("[TB] FAIL wrap_count op %0d: got replace %b count %0d expected 1 %0d", i + 1, oReplace, opCount, expCount); end
    end
    sValid = 1'b0;
    waitIdle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
